fetch_queue: RTL

Prefetching instruction-fetch front end for the pipelined RV32I core. It replaces the single-cycle fetch/imemory pairing: it holds the fetch PC, issues sequential reads to a 1-cycle-latency instruction memory, and buffers returned {pc, insn} pairs in a small FIFO. Decode drains the FIFO over a valid/ready handshake. Execute redirects the block on taken branches and jumps, which flushes all buffered and in-flight fetches.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction-fetch front end for the RV32I core.
// Ports: clk, reset (sync, active-high); imem_req/imem_addr/imem_rdata
// (1-cycle read memory); redirect_valid/redirect_pc (flush + restart);
// out_valid/out_ready/out_pc/out_insn (decode handshake); count (occupancy).
module fetch_queue #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [DWIDTH-1:0] RESET_PC = 32'h0100_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [DWIDTH-1:0]      imem_addr,
    input  logic [DWIDTH-1:0]      imem_rdata,
    input  logic                   redirect_valid,
    input  logic [DWIDTH-1:0]      redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_pc,
    output logic [DWIDTH-1:0]      out_insn,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [DWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DWIDTH-1:0] mem_pc   [DEPTH];
    logic [DWIDTH-1:0] mem_insn [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Occupancy plus the read in flight must fit, so a returning
    // response always has a free slot.
    assign credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue  = !reset && !redirect_valid
                 && (credit < (CW+1)'(DEPTH));
    assign push   = inflight_q && !redirect_valid && !reset;

    assign out_valid = !reset && (count_q != '0);
    assign pop       = out_valid && out_ready;

    assign imem_req  = issue;
    assign imem_addr = reset ? RESET_PC : fetch_pc_q;
    assign out_pc    = out_valid ? mem_pc[head_q]   : '0;
    assign out_insn  = out_valid ? mem_insn[head_q] : '0;
    assign count     = reset ? '0 : count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (redirect_valid) begin
            // Flush: a pop this cycle is simply absorbed by the clear.
            fetch_pc_d = {redirect_pc[DWIDTH-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + DWIDTH'(4);
            if (push)  tail_d     = tail_q + AW'(1);
            if (pop)   head_d     = head_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_q]   <= inflight_pc_q;
            mem_insn[tail_q] <= imem_rdata;
        end
    end

endmodule
